hash_nonce_search: RTL

//  Synthesizable initiator for the micro-hash core: drives array_numbers0..15 and ready,

---
 rtl/hash_nonce_search.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hash_nonce_search.sv
// hash_nonce_search: drives one micro-hash core with header+nonce and walks the nonce
// until both leading hash bytes fall strictly below the target or the range is exhausted.
`default_nettype none

module hash_nonce_search #(
  parameter int unsigned HASH_LATENCY = 40,
  parameter logic [31:0] MAX_NONCE    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [95:0] header,
  input  logic [7:0]  target,
  input  logic [7:0]  hash_array0,
  input  logic [7:0]  hash_array1,
  input  logic [7:0]  hash_array2,
  output logic [7:0]  array_numbers0,
  output logic [7:0]  array_numbers1,
  output logic [7:0]  array_numbers2,
  output logic [7:0]  array_numbers3,
  output logic [7:0]  array_numbers4,
  output logic [7:0]  array_numbers5,
  output logic [7:0]  array_numbers6,
  output logic [7:0]  array_numbers7,
  output logic [7:0]  array_numbers8,
  output logic [7:0]  array_numbers9,
  output logic [7:0]  array_numbers10,
  output logic [7:0]  array_numbers11,
  output logic [7:0]  array_numbers12,
  output logic [7:0]  array_numbers13,
  output logic [7:0]  array_numbers14,
  output logic [7:0]  array_numbers15,
  output logic        ready,
  output logic        busy,
  output logic        found,
  output logic        fail,
  output logic [31:0] nonce_out,
  output logic [23:0] hash_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] LAT_LAST = 8'(HASH_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [95:0] header_q, header_d;
  logic [7:0]  target_q, target_d;
  logic [31:0] nonce_q, nonce_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        found_q, found_d;
  logic        fail_q, fail_d;
  logic [31:0] nonce_out_q, nonce_out_d;
  logic [23:0] hash_out_q, hash_out_d;
  logic        hit;

  assign hit = (hash_array0 < target_q) && (hash_array1 < target_q);

  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    target_d    = target_q;
    nonce_d     = nonce_q;
    cnt_d       = cnt_q;
    found_d     = found_q;
    fail_d      = fail_q;
    nonce_out_d = nonce_out_q;
    hash_out_d  = hash_out_q;
    // abort outranks both a start request and a hit evaluated in the same cycle
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_RUN;
            header_d = header;
            target_d = target;
            nonce_d  = 32'd0;
            cnt_d    = 8'd0;
            found_d  = 1'b0;
            fail_d   = 1'b0;
          end
        end
        S_RUN: begin
          if (cnt_q == LAT_LAST) begin
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_CHECK: begin
          if (hit) begin
            state_d     = S_DONE;
            found_d     = 1'b1;
            nonce_out_d = nonce_q;
            hash_out_d  = {hash_array0, hash_array1, hash_array2};
          end else if (nonce_q == MAX_NONCE) begin
            state_d = S_DONE;
            fail_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            nonce_d = nonce_q + 32'd1;
            cnt_d   = 8'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      header_q    <= '0;
      target_q    <= '0;
      nonce_q     <= '0;
      cnt_q       <= '0;
      found_q     <= 1'b0;
      fail_q      <= 1'b0;
      nonce_out_q <= '0;
      hash_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      target_q    <= target_d;
      nonce_q     <= nonce_d;
      cnt_q       <= cnt_d;
      found_q     <= found_d;
      fail_q      <= fail_d;
      nonce_out_q <= nonce_out_d;
      hash_out_q  <= hash_out_d;
    end
  end

  assign {array_numbers0, array_numbers1, array_numbers2,  array_numbers3,
          array_numbers4, array_numbers5, array_numbers6,  array_numbers7,
          array_numbers8, array_numbers9, array_numbers10, array_numbers11} = header_q;
  assign {array_numbers12, array_numbers13, array_numbers14, array_numbers15} = nonce_q;

  assign ready     = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN) || (state_q == S_CHECK);
  assign found     = found_q;
  assign fail      = fail_q;
  assign nonce_out = nonce_out_q;
  assign hash_out  = hash_out_q;

endmodule

`default_nettype wire
